// File: rtl/ldpc_ber_tester_pkg.sv
// Shared types and defaults for the LDPC BER tester SNR sweep controller.
// Holds the sweep state encoding and the default datapath reset length.
package ldpc_ber_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_RUN,
    ST_DRAIN,
    ST_SETTLE,
    ST_REPORT,
    ST_NEXT
  } sweep_state_e;

  localparam int unsigned RESET_CYCLES_DEFAULT = 4;
  localparam int unsigned NUM_POINTS_MAX       = 16;

  // Index of the last point to sweep: 0 counts as 1 point, anything above the table depth is clamped.
  function automatic logic [3:0] last_point(input logic [4:0] np, input int unsigned depth);
    logic [4:0] n;
    n = np;
    if (n == 5'd0) n = 5'd1;
    if (n > 5'(depth)) n = 5'(depth);
    return 4'(n - 5'd1);
  endfunction

endpackage

// File: rtl/ldpc_ber_tester_sweep_table.sv
// SNR point table: one noise factor/offset pair per sweep point.
// Single write port, combinational read addressed by the current point index.
module ldpc_ber_tester_sweep_table #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [15:0] wfactor_i,
  input  logic [7:0]  woffset_i,
  input  logic [3:0]  raddr_i,
  output logic [15:0] rfactor_o,
  output logic [7:0]  roffset_o
);

  logic [15:0] factor_q [DEPTH];
  logic [7:0]  offset_q [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        factor_q[i] <= '0;
        offset_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr_i == 4'(i)) begin
          factor_q[i] <= wfactor_i;
          offset_q[i] <= woffset_i;
        end
      end
    end
  end

  always_comb begin
    rfactor_o = '0;
    roffset_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_i == 4'(i)) begin
        rfactor_o = factor_q[i];
        roffset_o = offset_q[i];
      end
    end
  end

endmodule

// File: rtl/ldpc_ber_tester_sweep_ctrl.sv
// SNR sweep controller: steps the BER datapath through the point table,
// resetting, running and draining it per point and handing back one result per point.
module ldpc_ber_tester_sweep_ctrl
  import ldpc_ber_tester_pkg::*;
#(
  parameter int unsigned NUM_POINTS   = 16,
  parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  num_points,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_factor,
  input  logic [7:0]  cfg_offset,
  input  logic [63:0] target_blocks,
  input  logic [63:0] max_errors,
  input  logic [63:0] finished_blocks,
  input  logic [63:0] bit_errors,
  input  logic [31:0] in_flight,
  output logic        en,
  output logic        sw_resetn,
  output logic [15:0] factor,
  output logic [7:0]  offset,
  output logic        busy,
  output logic        done,
  output logic [3:0]  point_idx,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [3:0]  res_point,
  output logic [63:0] res_blocks,
  output logic [63:0] res_errors
);

  localparam logic [15:0] RstLast = 16'(RESET_CYCLES - 1);

  sweep_state_e state_q;
  logic [15:0]  rst_cnt_q;
  logic [3:0]   point_idx_q, last_q;
  logic         abort_flag_q;
  logic         en_q, sw_resetn_q, busy_q, done_q, res_valid_q;
  logic [15:0]  factor_q;
  logic [7:0]   offset_q;
  logic [3:0]   res_point_q;
  logic [63:0]  res_blocks_q, res_errors_q;
  logic [15:0]  tbl_factor;
  logic [7:0]   tbl_offset;
  logic         stop_hit;

  ldpc_ber_tester_sweep_table #(.DEPTH(NUM_POINTS)) u_table (
    .clk       (clk),
    .resetn    (resetn),
    .we_i      (cfg_we && (state_q == ST_IDLE)),
    .waddr_i   (cfg_addr),
    .wfactor_i (cfg_factor),
    .woffset_i (cfg_offset),
    .raddr_i   (point_idx_q),
    .rfactor_o (tbl_factor),
    .roffset_o (tbl_offset)
  );

  assign stop_hit = (finished_blocks >= target_blocks) ||
                    ((max_errors != 64'd0) && (bit_errors >= max_errors));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      rst_cnt_q    <= '0;
      point_idx_q  <= '0;
      last_q       <= '0;
      abort_flag_q <= 1'b0;
      en_q         <= 1'b0;
      sw_resetn_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      factor_q     <= '0;
      offset_q     <= '0;
      res_point_q  <= '0;
      res_blocks_q <= '0;
      res_errors_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_q      <= ST_RST;
            point_idx_q  <= '0;
            last_q       <= last_point(num_points, NUM_POINTS);
            rst_cnt_q    <= '0;
            abort_flag_q <= 1'b0;
            busy_q       <= 1'b1;
            sw_resetn_q  <= 1'b0;
            en_q         <= 1'b0;
          end
        end
        ST_RST: begin
          factor_q <= tbl_factor;
          offset_q <= tbl_offset;
          if (abort) begin
            state_q      <= ST_DRAIN;
            abort_flag_q <= 1'b1;
          end else if (rst_cnt_q == RstLast) begin
            state_q     <= ST_RUN;
            en_q        <= 1'b1;
            sw_resetn_q <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + 16'd1;
          end
        end
        ST_RUN: begin
          if (abort || stop_hit) begin
            state_q <= ST_DRAIN;
            en_q    <= 1'b0;
            if (abort) abort_flag_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (in_flight == 32'd0) begin
            if (abort_flag_q || abort) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_SETTLE;
            end
          end else if (abort) begin
            abort_flag_q <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (abort_flag_q || abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q      <= ST_REPORT;
            res_valid_q  <= 1'b1;
            res_point_q  <= point_idx_q;
            res_blocks_q <= finished_blocks;
            res_errors_q <= bit_errors;
          end
        end
        ST_REPORT: begin
          if (abort) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (res_ready) begin
            state_q     <= ST_NEXT;
            res_valid_q <= 1'b0;
          end
        end
        ST_NEXT: begin
          if (point_idx_q == last_q) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q     <= ST_RST;
            point_idx_q <= point_idx_q + 4'd1;
            rst_cnt_q   <= '0;
            sw_resetn_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // An abort during REPORT withdraws the result in the same cycle, so no handshake can complete.
  assign res_valid  = res_valid_q && !abort;
  assign en         = en_q;
  assign sw_resetn  = sw_resetn_q;
  assign factor     = factor_q;
  assign offset     = offset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign point_idx  = point_idx_q;
  assign res_point  = res_point_q;
  assign res_blocks = res_blocks_q;
  assign res_errors = res_errors_q;

endmodule

// File: doc/ldpc_ber_tester_sweep_ctrl.md
LDPC_BER_TESTER_SWEEP_CTRL -- requirements
Module: ldpc_ber_tester_sweep_ctrl

Interface
REQ-001 Parameter: NUM_POINTS, default 16, depth of the SNR point table (power of two, max 16).
REQ-002 Parameter: RESET_CYCLES, default 4, number of cycles sw_resetn is held low per point.
REQ-003 clk  in  1  datapath clock; all logic in this single domain.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 start / abort  in  1 each  single-cycle command pulses.
REQ-006 num_points  in  5  number of table points to sweep, 1..NUM_POINTS; 0 is treated as 1.
REQ-007 cfg_we  in  1; cfg_addr  in  4; cfg_factor  in  16; cfg_offset  in  8  point table write port.
REQ-008 target_blocks  in  64  per-point block goal; max_errors  in  64  per-point error stop, 0 = disabled.
REQ-009 finished_blocks  in  64; bit_errors  in  64; in_flight  in  32  datapath counters.
REQ-010 en / sw_resetn  out  1 each  datapath enable and datapath software reset (active-low).
REQ-011 factor  out  16; offset  out  8  active point noise configuration.
REQ-012 busy  out  1; done  out  1  one-cycle sweep-complete pulse; point_idx  out  4  current point.
REQ-013 res_valid  out  1; res_ready  in  1; res_point  out  4; res_blocks  out  64; res_errors  out  64  per-point result handshake.

Function
REQ-014 State machine: IDLE, RST, RUN, DRAIN, SETTLE, REPORT, NEXT.
REQ-015 IDLE: start -> RST with point_idx=0; cfg_we is accepted only in IDLE and ignored otherwise.
REQ-016 RST: sw_resetn=0, en=0, factor/offset driven from table[point_idx]; exit to RUN after exactly RESET_CYCLES cycles.
REQ-017 RUN: en=1, sw_resetn=1; exit to DRAIN when finished_blocks >= target_blocks, or when max_errors!=0 and bit_errors >= max_errors; both comparisons are unsigned 64-bit.
REQ-018 DRAIN: en=0; exit to SETTLE on the first cycle with in_flight==0.
REQ-019 SETTLE: one cycle; on exit, capture finished_blocks, bit_errors and point_idx into res_* registers -> REPORT.
REQ-020 REPORT: res_valid=1, res_* stable until the res_ready handshake; on the handshake cycle go to NEXT.
REQ-021 NEXT: if point_idx == num_points-1, pulse done for one cycle -> IDLE; else increment point_idx -> RST.
REQ-022 abort in RST or RUN -> DRAIN with an abort flag set; abort in DRAIN or SETTLE sets the flag; abort in REPORT drops res_valid immediately; an aborted sweep returns to IDLE after DRAIN, emits no result and no done.
REQ-023 When start and abort are asserted in the same cycle in IDLE, abort wins and the FSM stays in IDLE; start outside IDLE is ignored.
REQ-024 target_blocks==0: RUN exits on its first cycle; a result is still reported.
REQ-025 busy=1 in every state except IDLE; factor/offset hold the last point's values in IDLE.
REQ-026 Latency: start to first en=1 is RESET_CYCLES+1 cycles.

Reset
REQ-027 On resetn low: state=IDLE, en=0, sw_resetn=0, busy=0, done=0, res_valid=0, point_idx=0, factor=0, offset=0, res_* =0, table entries=0.
REQ-028 In IDLE after reset, sw_resetn stays 0 until the first RST state exits (datapath held in reset while idle).
REQ-029 resetn assertion mid-sweep aborts immediately with no result or done emitted.

Structure
REQ-030 The state encoding and RESET_CYCLES default belong in the shared package ldpc_ber_tester_pkg.
REQ-031 The point table is a sub-module ldpc_ber_tester_sweep_table: register array, one write port, asynchronous read by point_idx.

Verification
REQ-032 Table {0:(0x1000,2),1:(0x0800,4)}, num_points=2, target=100 -> two results with res_point 0 then 1, each res_blocks>=100, then one done pulse, busy low.
REQ-033 max_errors=5 with bit_errors ramping past 5 before 100 blocks -> RUN exits; res_errors>=5 and res_blocks<100.
REQ-034 in_flight held at 3 for 10 cycles after RUN exits -> en=0 throughout DRAIN; capture occurs 1 cycle after in_flight==0.
REQ-035 res_ready held low for 50 cycles -> res_* stable and FSM in REPORT for all 50 cycles; no point advance.
REQ-036 abort in RUN of point 0 -> DRAIN, then IDLE; no res_valid, no done; busy falls after in_flight==0.
REQ-037 resetn pulsed low during RUN -> all outputs at reset values asynchronously; subsequent start sweeps from point 0.
